// File: rtl/lane_pack_pkg.sv
// Shared types for the lane word packer.
// Lane/word layouts and the beat kind encoding.
package lane_pack_pkg;

  localparam int LANES = 8;

  typedef struct packed {
    logic [1:0][1:0][1:0] bits;
  } lane_t;

  typedef union packed {
    logic [LANES-1:0][7:0]  b;
    logic [3:0][15:0]       h;
    lane_t [LANES-1:0]      l;
  } word_t;

  typedef enum logic [1:0] {
    K_BYTE  = 2'd0,
    K_HALF  = 2'd1,
    K_FLUSH = 2'd2,
    K_RSVD  = 2'd3
  } kind_e;

  localparam bit LANE_BITS_OK = ($bits(lane_t) == 8);
  localparam bit WORD_BITS_OK = ($bits(word_t) == 64);

endpackage

// File: rtl/lane_out_slot.sv
// One-entry valid/ready holding register for packed words.
// Also counts words handed to the consumer.
module lane_out_slot #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [63:0]      load_data,
  input  logic [7:0]       load_mask,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic [7:0]       out_mask,
  output logic [CNT_W-1:0] words_out
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A load in the same cycle as a pop replaces the word being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      words_out <= '0;
    end else begin
      if (out_valid && out_ready) begin
        words_out <= words_out + ONE;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_mask  <= load_mask;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_word_packer.sv
// Packs byte/halfword beats into 64-bit words with a lane mask.
// Owns the accumulator, lane index and beat-kind decode.
module lane_word_packer
  import lane_pack_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [LANES-1:0] out_mask,
  output logic [CNT_W-1:0] words_out,
  output logic             err_kind
);

  if (!LANE_BITS_OK || !WORD_BITS_OK || LANES != 8) begin : g_bad_cfg
    $error("lane_word_packer: unsupported lane layout");
  end

  word_t      acc_q;
  word_t      acc_d;
  word_t      emit_word;
  logic [7:0] mask_q;
  logic [7:0] mask_d;
  logic [7:0] emit_mask;
  logic [3:0] idx_q;
  logic [3:0] idx_d;
  logic [2:0] base;
  logic [2:0] base1;
  logic       load;
  logic       err_d;
  logic       accept;
  logic       is_byte;
  logic       is_half;
  logic       is_flush;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_byte  = (in_kind == K_BYTE);
  assign is_half  = (in_kind == K_HALF);
  assign is_flush = (in_kind == K_FLUSH);

  // A half never straddles a lane pair: odd idx skips one lane.
  assign base  = idx_q[2:0] + {2'b00, idx_q[0]};
  assign base1 = base + 3'd1;

  always_comb begin
    acc_d     = acc_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    emit_word = acc_q;
    emit_mask = mask_q;
    load      = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_byte: begin
          acc_d.b[idx_q[2:0]] = in_data[7:0];
          mask_d[idx_q[2:0]]  = 1'b1;
          idx_d               = idx_q + 4'd1;
        end
        is_half: begin
          if (idx_q == 4'd7) begin
            load      = 1'b1;
            acc_d     = '0;
            acc_d.h[0] = in_data;
            mask_d    = 8'h03;
            idx_d     = 4'd2;
          end else begin
            acc_d.b[base]  = in_data[7:0];
            acc_d.b[base1] = in_data[15:8];
            mask_d[base]   = 1'b1;
            mask_d[base1]  = 1'b1;
            idx_d          = {1'b0, base} + 4'd2;
          end
        end
        is_flush: begin
          load   = |mask_q;
          acc_d  = '0;
          mask_d = '0;
          idx_d  = '0;
        end
        default: err_d = 1'b1;
      endcase
      if (idx_d == 4'd8) begin
        load      = 1'b1;
        emit_word = acc_d;
        emit_mask = mask_d;
        acc_d     = '0;
        mask_d    = '0;
        idx_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      err_kind <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      err_kind <= err_d;
    end
  end

  lane_out_slot #(
    .CNT_W(CNT_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (emit_word),
    .load_mask (emit_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .words_out (words_out)
  );

endmodule

// File: tb/tb_lane_word_packer.sv
// Randomized and directed bench for lane_word_packer.
// Reference model works on a byte array and a word queue.
module tb_lane_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic [15:0] words_out;
  logic        err_kind;

  int checks = 0;
  int errors = 0;

  lane_word_packer #(.LANES(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .words_out (words_out),
    .err_kind  (err_kind)
  );

  always #5 clk = ~clk;

  // model state
  logic [7:0]  m_lane [8];
  logic [7:0]  m_lmask;
  int          m_pos;
  logic        m_v;
  logic [63:0] m_word;
  logic [7:0]  m_wmask;
  int          m_cnt;
  logic        m_err;
  logic        m_got;
  logic [63:0] m_nw;
  logic [7:0]  m_nm;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_lane[i] = 8'h00;
    m_lmask = 8'h00;
    m_pos   = 0;
  endtask

  task automatic m_emit();
    m_nw = 64'h0;
    for (int i = 0; i < 8; i++) m_nw = m_nw | (64'(m_lane[i]) << (8 * i));
    m_nm  = m_lmask;
    m_got = 1'b1;
    m_clear();
  endtask

  task automatic m_put(input logic [7:0] b);
    m_lane[m_pos] = b;
    m_lmask = m_lmask | (8'h01 << m_pos);
    m_pos++;
    if (m_pos == 8) m_emit();
  endtask

  task automatic m_reset();
    m_clear();
    m_v     = 1'b0;
    m_word  = 64'h0;
    m_wmask = 8'h00;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  // One clock: drive, check against model, advance model, pass edge.
  task automatic step(input logic v, input logic [1:0] k,
                      input logic [15:0] d, input logic ordy,
                      input logic r);
    logic acc;
    logic pop;
    in_valid  = v;
    in_kind   = k;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #1;
    check("in_ready", in_ready, !m_v || ordy);
    check("out_valid", out_valid, m_v);
    if (m_v) begin
      check("out_data", out_data, m_word);
      check("out_mask", out_mask, m_wmask);
    end
    check("words_out", words_out, m_cnt[15:0]);
    check("err_kind", err_kind, m_err);
    acc = v && (!m_v || ordy);
    pop = m_v && ordy;
    if (r) begin
      m_reset();
    end else begin
      m_got = 1'b0;
      if (pop) m_cnt++;
      m_err = acc && (k == 2'd3);
      if (acc) begin
        case (k)
          2'd0: m_put(d[7:0]);
          2'd1: begin
            if (m_pos == 7) m_emit();
            else if (m_pos % 2 == 1) m_pos++;
            m_put(d[7:0]);
            m_put(d[15:8]);
          end
          2'd2: begin
            if (m_lmask != 8'h00) m_emit();
            else m_clear();
          end
          default: ;
        endcase
      end
      if (m_got) begin
        m_v     = 1'b1;
        m_word  = m_nw;
        m_wmask = m_nm;
      end else if (pop) begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bytes8(input logic [7:0] first, input logic ordy);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, {8'h00, first + 8'(i)}, ordy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_kind   = 2'd0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_mask", out_mask, 8'h00);
    check("rst_words_out", words_out, 16'h0);
    check("rst_err_kind", err_kind, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // bytes 0x11..0x88
    for (int i = 1; i <= 8; i++) step(1'b1, 2'd0, {8'h00, 8'(i * 8'h11)}, 1'b1, 1'b0);
    check("b8_valid", out_valid, 1'b1);
    check("b8_data", out_data, 64'h8877665544332211);
    check("b8_mask", out_mask, 8'hFF);
    step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    check("b8_count", words_out, 16'd1);

    // half/byte/half with skipped lane 3, then flush
    step(1'b1, 2'd1, 16'hBBAA, 1'b1, 1'b0);
    step(1'b1, 2'd0, 16'h00CC, 1'b1, 1'b0);
    step(1'b1, 2'd1, 16'hEEDD, 1'b1, 1'b0);
    step(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0);
    check("skip_data", out_data, 64'h0000EEDD00CCBBAA);
    check("skip_mask", out_mask, 8'h37);

    // half at idx 7 closes the word early
    for (int i = 1; i <= 7; i++) step(1'b1, 2'd0, 16'(i), 1'b1, 1'b0);
    step(1'b1, 2'd1, 16'h2211, 1'b1, 1'b0);
    check("idx7_mask", out_mask, 8'h7F);
    step(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0);
    check("idx7_f_data", out_data, 64'h0000000000002211);
    check("idx7_f_mask", out_mask, 8'h03);

    // empty flush emits nothing
    step(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0);
    check("eflush_valid", out_valid, 1'b0);
    check("eflush_count", words_out, 16'd4);

    // stall with held word
    bytes8(8'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd0, 16'h0099, 1'b0, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_data", out_data, 64'h4746454443424140);
    end
    bytes8(8'hA0, 1'b1);
    step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);

    // reserved kind, then reset mid-word
    step(1'b1, 2'd0, 16'h0055, 1'b1, 1'b0);
    step(1'b1, 2'd3, 16'hFFFF, 1'b1, 1'b0);
    check("rsvd_pulse", err_kind, 1'b1);
    step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    check("rsvd_drop", err_kind, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 16'h0077, 1'b1, 1'b0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_count", words_out, 16'd0);
    check("mrst_in_ready", in_ready, 1'b1);
    bytes8(8'h01, 1'b1);
    check("mrst_mask", out_mask, 8'hFF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kr;
      logic [1:0] k;
      kr = int'($urandom_range(0, 15));
      k  = (kr < 7) ? 2'd0 : (kr < 13) ? 2'd1 : (kr < 15) ? 2'd2 : 2'd3;
      step($urandom_range(0, 9) < 8, k, 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_word_packer.md
# lane_word_packer

Sequencer that fills the 64-bit packed word (union of eight 8-bit lanes, four 16-bit halves, eight lane structs) from a narrow input stream. Accepts byte or halfword beats, places each at the next free lane, and emits completed or flushed words with a per-lane valid mask through a one-entry valid/ready output slot. Sits between narrow producers and any consumer of the 64-bit word, and owns the lane-index bookkeeping for that word.

## Interface
- `LANES`, 8: lanes per word; the design supports 8 only.
- `CNT_W`, 16: width of the emitted-word counter.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_kind`  in  2  0=BYTE, 1=HALF, 2=FLUSH, 3=reserved.
- `in_data`  in  16  BYTE uses [7:0]; HALF uses [15:0], low byte goes to the lower lane.
- `out_valid`  out  1  word held in the slot.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  64  word; lane i is `out_data[8i+7:8i]`.
- `out_mask`  out  8  bit i set = lane i written.
- `words_out`  out  CNT_W  count of words emitted; wraps.
- `err_kind`  out  1  one-cycle pulse when a reserved kind is accepted.

## Operation
- State:
  - accumulator `acc` (64 bits)
  - `acc_mask` (8 bits)
  - lane index `idx` (0..8)
  - output slot
- Backpressure: `in_ready = !out_valid || out_ready`, combinational. Any accepted beat may complete a word.
- BYTE: write lane `idx`, set its mask bit, `idx += 1`.
- HALF:
  - `idx` odd (1, 3 or 5): skip lane `idx` (its mask bit stays 0), then write lanes `idx+1` and `idx+2`.
  - `idx == 7`: the current word closes with lane 7 unwritten (mask 0x7F). The half goes to lanes 0–1 of a new word, leaving `idx = 2`.
- Completion: when `idx` reaches 8, load the slot with `acc`/`acc_mask`, then clear `acc`, `acc_mask` and `idx`.
- FLUSH:
  - `acc_mask != 0`: emit the partial word; unwritten lanes read 0.
  - `acc_mask == 0`: no word is emitted.
  - Either way, reset `idx` to 0.
- Reserved kind: the beat is consumed, state is unchanged, and `err_kind` pulses.
- Slot: loading takes priority; a load and a pop in the same cycle replace the held word. `words_out` increments on each `out_valid && out_ready`.
- Reset mid-word: partial data and the slot contents are discarded and nothing is emitted.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_mask=0`, `words_out=0`, `err_kind=0`; internally `acc=0`, `acc_mask=0`, `idx=0`. `in_ready` is 1 during and after reset.
- Latency: the beat that completes or flushes a word in cycle N gives `out_valid=1` in cycle N+1.
- Sustained rate:
  - BYTE stream: one word per 8 beats.
  - HALF stream: one word per 4 beats.
- Once asserted, `out_valid` and `out_data` stay stable until the word is taken.
- Stall: with the slot held and `out_ready=0`, `in_ready=0`. No beat is lost and the accumulator is unchanged.

## Structure
- Package `lane_pack_pkg` holds:
  - `lane_t`: struct packed of `logic [1:0][1:0][1:0]`.
  - `word_t`: union packed with views `logic [LANES-1:0][7:0]`, `logic [3:0][15:0]` and `lane_t [LANES-1:0]`.
  - `kind_e` enum.
  - `LANES` constant.
  - Static checks: `$bits(lane_t)==8` and `$bits(word_t)==64`.
- Sub-module `lane_out_slot`: one-entry valid/ready register holding `out_data`, `out_mask` and `words_out`.
- Top module: accumulator, index logic and kind decode.

## Test plan
- BYTE beats 0x11..0x88 with `out_ready=1` → one cycle after the 8th beat, `out_data=0x8877665544332211`, `out_mask=0xFF`, `words_out=1`.
- HALF 0xBBAA, BYTE 0xCC, HALF 0xEEDD → lane 3 is skipped: `out_data` lanes 0–4 = AA, BB, CC, 00, DD, then lane 5 = EE after FLUSH; `out_mask=0x37`.
- Seven BYTE beats, then HALF 0x2211 → word 1 has `out_mask=0x7F`. Then FLUSH → word 2 has `out_data=0x0000000000002211`, `out_mask=0x03`.
- FLUSH on an empty accumulator → no `out_valid`; `words_out` unchanged.
- `out_ready=0` while a word is held → `in_ready=0` and the held word stays stable. After 5 cycles raise `out_ready` → the word pops and the next 8-byte word follows without loss.
- `in_kind=3` → `err_kind` pulses for 1 cycle, `idx` unchanged. Then assert `rst` after 3 bytes → all outputs return to reset values, and a fresh 8-byte sequence produces a word with `out_mask=0xFF`.
